// File: rtl/change_dispenser_if.sv
// Coin chute handshake between the change dispenser and the chute.
// master: drives coin_valid/coin_value, samples coin_ready.
interface change_dispenser_if;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       coin_ready;

   modport master (
      output coin_valid,
      output coin_value,
      input  coin_ready
   );

   modport slave (
      input  coin_valid,
      input  coin_value,
      output coin_ready
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin change dispenser with four coin tubes (50/10/5/1 TWD).
// Ports: clock, reset (sync, active-high); start/amount request;
//   refill/refill_sel/refill_count tube top-up; coin (chute handshake,
//   master side); busy/done/fault status; shortfall, dispensed_total;
//   stock_50/10/5/1 tube counts.
module change_dispenser #(
   parameter int unsigned STOCK_INIT = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         amount,
   input  logic                refill,
   input  logic [1:0]          refill_sel,
   input  logic [15:0]         refill_count,
   change_dispenser_if.master  coin,
   output logic                busy,
   output logic                done,
   output logic                fault,
   output logic [31:0]         shortfall,
   output logic [31:0]         dispensed_total,
   output logic [15:0]         stock_50,
   output logic [15:0]         stock_10,
   output logic [15:0]         stock_5,
   output logic [15:0]         stock_1
);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      DISPENSE,
      DONE,
      FAULT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] remaining_q, remaining_d;
   logic [31:0] dispensed_q, dispensed_d;
   logic [31:0] shortfall_q, shortfall_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic [7:0]  value_q, value_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] stock_q [4];
   logic [15:0] stock_d [4];
   logic [3:0]  dec;
   logic        pick_ok;
   logic [1:0]  pick;
   logic        accept;

   // Tube index to coin value: 0=50, 1=10, 2=5, 3=1.
   function automatic logic [7:0] denom(input logic [1:0] idx);
      logic [7:0] v;
      v = 8'd1;
      case (idx)
         2'd0: v = 8'd50;
         2'd1: v = 8'd10;
         2'd2: v = 8'd5;
         2'd3: v = 8'd1;
         default: v = 8'd1;
      endcase
      return v;
   endfunction

   assign accept = valid_q && coin.coin_ready;

   // Largest eligible coin: scan smallest first so the largest
   // eligible tube overwrites the pick last.
   always_comb begin
      pick_ok = 1'b0;
      pick    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (stock_q[i] != 16'd0 &&
             {24'd0, denom(2'(i))} <= remaining_q) begin
            pick_ok = 1'b1;
            pick    = 2'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      dispensed_d = dispensed_q;
      shortfall_d = shortfall_q;
      valid_d     = 1'b0;
      value_d     = 8'd0;
      done_d      = 1'b0;
      fault_d     = 1'b0;
      sel_d       = sel_q;
      dec         = 4'b0000;

      case (state_q)
         IDLE: begin
            if (start) begin
               remaining_d = amount;
               dispensed_d = 32'd0;
               shortfall_d = 32'd0;
               state_d     = SELECT;
            end
         end
         SELECT: begin
            if (remaining_q == 32'd0) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else if (pick_ok) begin
               valid_d = 1'b1;
               value_d = denom(pick);
               sel_d   = pick;
               state_d = DISPENSE;
            end else begin
               fault_d     = 1'b1;
               shortfall_d = remaining_q;
               state_d     = FAULT;
            end
         end
         DISPENSE: begin
            if (accept) begin
               remaining_d = remaining_q - {24'd0, value_q};
               dispensed_d = dispensed_q + {24'd0, value_q};
               dec[sel_q]  = 1'b1;
               state_d     = SELECT;
            end else begin
               valid_d = 1'b1;
               value_d = value_q;
            end
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // Refill and coin decrement may hit the same tube in one cycle.
   // The 17-bit sum cannot underflow: a tube is only decremented
   // after it was seen non-empty and refill never subtracts.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         logic [16:0] sum;
         sum = {1'b0, stock_q[i]};
         if (refill && refill_sel == 2'(i))
            sum = sum + {1'b0, refill_count};
         sum = sum - {16'd0, dec[i]};
         stock_d[i] = sum[16] ? 16'hFFFF : sum[15:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= 32'd0;
         dispensed_q <= 32'd0;
         shortfall_q <= 32'd0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         value_q     <= 8'd0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         sel_q       <= 2'd0;
         for (int i = 0; i < 4; i++)
            stock_q[i] <= 16'(STOCK_INIT);
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         dispensed_q <= dispensed_d;
         shortfall_q <= shortfall_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         value_q     <= value_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
         sel_q       <= sel_d;
         for (int i = 0; i < 4; i++)
            stock_q[i] <= stock_d[i];
      end
   end

   assign coin.coin_valid = valid_q;
   assign coin.coin_value = value_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign fault           = fault_q;
   assign shortfall       = shortfall_q;
   assign dispensed_total = dispensed_q;
   assign stock_50        = stock_q[0];
   assign stock_10        = stock_q[1];
   assign stock_5         = stock_q[2];
   assign stock_1         = stock_q[3];

endmodule
